// File: rtl/dau_output_encoder_pkg.sv
// Shared DAU symbol codes (the dau_symbols.vh set, guarded for one definition)
// and the digit-to-symbol helper used by the print-path encoder.
`ifndef DAU_SYMBOLS_VH
`define DAU_SYMBOLS_VH
`define DAU_SYM_WIDTH    5
`define DAU_SYM_0        5'd0
`define DAU_SYM_1        5'd1
`define DAU_SYM_2        5'd2
`define DAU_SYM_3        5'd3
`define DAU_SYM_4        5'd4
`define DAU_SYM_5        5'd5
`define DAU_SYM_6        5'd6
`define DAU_SYM_7        5'd7
`define DAU_SYM_8        5'd8
`define DAU_SYM_9        5'd9
`define DAU_SYM_MINUS    5'd10
`define DAU_SYM_COMMA    5'd11
`define DAU_SYM_NEW_LINE 5'd12
`define DAU_SYM_INVALID  5'd31
`endif

package dau_output_encoder_pkg;

  localparam int SYM_W = `DAU_SYM_WIDTH;
  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t SYM_0        = `DAU_SYM_0;
  localparam sym_t SYM_9        = `DAU_SYM_9;
  localparam sym_t SYM_MINUS    = `DAU_SYM_MINUS;
  localparam sym_t SYM_COMMA    = `DAU_SYM_COMMA;
  localparam sym_t SYM_NEW_LINE = `DAU_SYM_NEW_LINE;
  localparam sym_t SYM_INVALID  = `DAU_SYM_INVALID;

  // Non-decimal nibbles saturate to the '9' symbol.
  function automatic sym_t digit_symbol(input logic [3:0] d);
    sym_t s;
    if (d > 4'd9) begin
      s = SYM_9;
    end else begin
      s = SYM_0 + sym_t'(d);
    end
    return s;
  endfunction

endpackage

// File: rtl/dau_lz_scan.sv
// Priority encoder over BCD digits: index of the most significant nonzero
// digit plus an all-zero flag.
module dau_lz_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 3
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [IDX_W-1:0]        top_idx,
  output logic                    all_zero
);

  // Scan upward so the highest nonzero digit wins.
  always_comb begin
    top_idx  = '0;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      top_idx  = (digits[4*i +: 4] != 4'd0) ? IDX_W'(i) : top_idx;
      all_zero = (digits[4*i +: 4] != 4'd0) ? 1'b0 : all_zero;
    end
  end

endmodule

// File: rtl/dau_output_encoder.sv
// Serialises a captured BCD stack value into DAU symbols over valid/ready.
// Optional leading-zero suppression: define DAU_ENC_LZ_SUPPRESS_EN.
module dau_output_encoder
  import dau_output_encoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int POS_WIDTH  = $clog2(NUM_DIGITS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_print_start,
  input  logic [4*NUM_DIGITS-1:0]   i_bcd,
  input  logic [POS_WIDTH-1:0]      i_comma_pos,
  input  logic                      i_sign,
  output logic                      o_valid,
  output logic [`DAU_SYM_WIDTH-1:0] o_symbol,
  input  logic                      i_ready,
  output logic                      o_done,
  output logic                      o_idle
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIGN  = 3'd1,
    ST_INT   = 3'd2,
    ST_COMMA = 3'd3,
    ST_FRAC  = 3'd4,
    ST_NL    = 3'd5
  } state_t;

  localparam logic [POS_WIDTH-1:0] MAX_POS = POS_WIDTH'(NUM_DIGITS - 1);
  localparam logic [POS_WIDTH-1:0] ONE     = POS_WIDTH'(1);

  state_t                  state_r, state_n;
  logic [4*NUM_DIGITS-1:0] bcd_r;
  logic [POS_WIDTH-1:0]    pos_r, idx_r, idx_n;
  logic [POS_WIDTH-1:0]    pos_clamp, first_idx;
  logic                    in_zero, capture, xfer, load;
  logic                    valid_n, done_n;
  sym_t                    symbol_n;

  assign pos_clamp = (i_comma_pos > MAX_POS) ? MAX_POS : i_comma_pos;

`ifdef DAU_ENC_LZ_SUPPRESS_EN
  logic [POS_WIDTH-1:0] top_idx;

  dau_lz_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (POS_WIDTH)
  ) u_lz_scan (
    .digits   (i_bcd),
    .top_idx  (top_idx),
    .all_zero (in_zero)
  );

  // Start at the top nonzero digit but never below the units position.
  assign first_idx = (top_idx > pos_clamp) ? top_idx : pos_clamp;
`else
  assign in_zero   = ~|i_bcd;
  assign first_idx = MAX_POS;
`endif

  assign capture = (state_r == ST_IDLE) && i_print_start;
  assign xfer    = o_valid && i_ready;
  // One cycle after capture the first symbol is loaded from the captured value.
  assign load    = (state_r != ST_IDLE) && !o_valid;

  // Next-state, digit index and handshake control.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    valid_n = o_valid || load;
    done_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_print_start) begin
          state_n = (i_sign && !in_zero) ? ST_SIGN : ST_INT;
          idx_n   = first_idx;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SIGN: begin
        state_n = xfer ? ST_INT : ST_SIGN;
      end
      ST_INT: begin
        if (!xfer) begin
          state_n = ST_INT;
        end else if (idx_r != pos_r) begin
          idx_n = idx_r - ONE;
        end else if (pos_r != '0) begin
          state_n = ST_COMMA;
        end else begin
          state_n = ST_NL;
        end
      end
      ST_COMMA: begin
        if (xfer) begin
          state_n = ST_FRAC;
          idx_n   = pos_r - ONE;
        end else begin
          state_n = ST_COMMA;
        end
      end
      ST_FRAC: begin
        if (!xfer) begin
          state_n = ST_FRAC;
        end else if (idx_r == '0) begin
          state_n = ST_NL;
        end else begin
          idx_n = idx_r - ONE;
        end
      end
      ST_NL: begin
        if (xfer) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = ST_NL;
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // Symbol presented for the upcoming state.
  always_comb begin
    symbol_n = SYM_INVALID;
    case (state_n)
      ST_SIGN:  symbol_n = SYM_MINUS;
      ST_INT:   symbol_n = digit_symbol(bcd_r[4*int'(idx_n) +: 4]);
      ST_COMMA: symbol_n = SYM_COMMA;
      ST_FRAC:  symbol_n = digit_symbol(bcd_r[4*int'(idx_n) +: 4]);
      ST_NL:    symbol_n = SYM_NEW_LINE;
      default:  symbol_n = SYM_INVALID;
    endcase
  end

  // State, capture and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      bcd_r    <= '0;
      pos_r    <= '0;
      o_valid  <= 1'b0;
      o_symbol <= SYM_INVALID;
      o_done   <= 1'b0;
      o_idle   <= 1'b1;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      o_valid <= valid_n;
      o_done  <= done_n;
      o_idle  <= (state_n == ST_IDLE);
      if (capture) begin
        bcd_r <= i_bcd;
        pos_r <= pos_clamp;
      end
      if (xfer || load) begin
        o_symbol <= symbol_n;
      end
    end
  end

endmodule

// File: tb/tb_dau_output_encoder.sv
// Bench for dau_output_encoder: table vectors, hand sequences (stall, restart
// attempt, reset abort) and randomized values checked against a symbol model.
module tb_dau_output_encoder;
  import dau_output_encoder_pkg::*;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        print_start;
  logic [15:0] bcd;
  logic [2:0]  comma_pos;
  logic        sign;
  logic        valid;
  sym_t        symbol;
  logic        ready;
  logic        done;
  logic        idle;

  int   checks = 0;
  int   errors = 0;
  sym_t exp_q[$];

  typedef struct {
    logic [15:0] bcd;
    logic [2:0]  pos;
    logic        sign;
    int          len;
    sym_t        syms[8];
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  dau_output_encoder #(.NUM_DIGITS(ND)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_print_start (print_start),
    .i_bcd         (bcd),
    .i_comma_pos   (comma_pos),
    .i_sign        (sign),
    .o_valid       (valid),
    .o_symbol      (symbol),
    .i_ready       (ready),
    .o_done        (done),
    .o_idle        (idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic sym_t dsym(input int v);
    return (v > 9) ? SYM_9 : SYM_0 + sym_t'(v);
  endfunction

  // Expected symbol list from the value's digits, comma and sign.
  task automatic build_model(input logic [15:0] b, input int pos, input logic s);
    int d[ND];
    int p, first;
    bit nz;
    exp_q.delete();
    nz = 1'b0;
    for (int i = 0; i < ND; i++) begin
      d[i] = int'(b[4*i +: 4]);
      if (d[i] != 0) nz = 1'b1;
    end
    p = (pos > ND - 1) ? ND - 1 : pos;
    if (s && nz) exp_q.push_back(SYM_MINUS);
    first = ND - 1;
`ifdef DAU_ENC_LZ_SUPPRESS_EN
    while (first > p && d[first] == 0) first--;
`endif
    for (int i = first; i >= p; i--) exp_q.push_back(dsym(d[i]));
    if (p > 0) begin
      exp_q.push_back(SYM_COMMA);
      for (int i = p - 1; i >= 0; i--) exp_q.push_back(dsym(d[i]));
    end
    exp_q.push_back(SYM_NEW_LINE);
  endtask

  // mode 0: ready always high, 1: toggling 1,0,1..., 2: random
  task automatic run_print(input logic [15:0] b, input logic [2:0] pos, input logic s,
                           input int mode, input bit inject);
    sym_t held, e;
    bit   stalled, last;
    int   cyc, k;
    check("idle_before_start", idle, 1);
    bcd = b; comma_pos = pos; sign = s; print_start = 1'b1;
    @(negedge clk);
    print_start = 1'b0;
    bcd = 16'($urandom); comma_pos = 3'($urandom); sign = 1'($urandom);
    check("capture_cycle_valid", valid, 0);
    check("capture_cycle_idle", idle, 0);
    stalled = 1'b0; last = 1'b0; cyc = 0; k = 0; held = SYM_INVALID;
    while (!last && cyc < 200) begin
      @(negedge clk);
      cyc++;
      print_start = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inject) bcd = 16'($urandom);
      check("stream_valid", valid, 1);
      check("stream_no_done", done, 0);
      if (stalled) check("hold_symbol", symbol, held);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (k % 2 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      k++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_symbol actual=%0h expected=none", symbol);
          last = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("symbol", symbol, e);
          if (e == SYM_NEW_LINE) last = 1'b1;
        end
        stalled = 1'b0;
      end else begin
        stalled = valid;
        held    = symbol;
      end
    end
    if (!last) begin
      checks++; errors++;
      $display("FAIL stream_timeout actual=%0d cycles expected=NEW_LINE transfer", cyc);
    end
    @(negedge clk);
    print_start = 1'b0;
    check("done_pulse", done, 1);
    check("done_idle", idle, 1);
    check("done_valid", valid, 0);
    @(negedge clk);
    check("done_single_cycle", done, 0);
  endtask

  task automatic load_table(input int i);
    exp_q.delete();
    for (int j = 0; j < tbl[i].len; j++) exp_q.push_back(tbl[i].syms[j]);
  endtask

  initial begin
    sym_t C, M, NL, X;
    logic [15:0] rb;
    C = SYM_COMMA; M = SYM_MINUS; NL = SYM_NEW_LINE; X = SYM_INVALID;
`ifdef DAU_ENC_LZ_SUPPRESS_EN
    tbl[0] = '{16'h0123, 3'd1, 1'b0, 5, '{dsym(1), dsym(2), C, dsym(3), NL, X, X, X}};
    tbl[1] = '{16'h0005, 3'd2, 1'b1, 6, '{M, dsym(0), C, dsym(0), dsym(5), NL, X, X}};
    tbl[2] = '{16'h0000, 3'd0, 1'b1, 2, '{dsym(0), NL, X, X, X, X, X, X}};
    tbl[3] = '{16'h0123, 3'd7, 1'b0, 6, '{dsym(0), C, dsym(1), dsym(2), dsym(3), NL, X, X}};
    tbl[4] = '{16'h00F1, 3'd0, 1'b0, 3, '{dsym(9), dsym(1), NL, X, X, X, X, X}};
`else
    tbl[0] = '{16'h0123, 3'd1, 1'b0, 6, '{dsym(0), dsym(1), dsym(2), C, dsym(3), NL, X, X}};
    tbl[1] = '{16'h0005, 3'd2, 1'b1, 7, '{M, dsym(0), dsym(0), C, dsym(0), dsym(5), NL, X}};
    tbl[2] = '{16'h0000, 3'd0, 1'b1, 5, '{dsym(0), dsym(0), dsym(0), dsym(0), NL, X, X, X}};
    tbl[3] = '{16'h0123, 3'd7, 1'b0, 6, '{dsym(0), C, dsym(1), dsym(2), dsym(3), NL, X, X}};
    tbl[4] = '{16'h00F1, 3'd0, 1'b0, 5, '{dsym(0), dsym(0), dsym(9), dsym(1), NL, X, X, X}};
`endif
    tbl[5] = '{16'h1000, 3'd3, 1'b1, 7, '{M, dsym(1), C, dsym(0), dsym(0), dsym(0), NL, X}};

    rst = 1'b1; print_start = 1'b0; bcd = 16'h0; comma_pos = 3'd0; sign = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_symbol", symbol, SYM_INVALID);
    check("reset_done", done, 0);
    check("reset_idle", idle, 1);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", idle, 1);
    check("post_reset_valid", valid, 0);

    for (int i = 0; i < 6; i++) begin
      load_table(i);
      run_print(tbl[i].bcd, tbl[i].pos, tbl[i].sign, 0, 1'b0);
    end

    // Ready toggling, then a restart attempt held on every stream cycle.
    load_table(0);
    run_print(tbl[0].bcd, tbl[0].pos, tbl[0].sign, 1, 1'b0);
    load_table(1);
    run_print(tbl[1].bcd, tbl[1].pos, tbl[1].sign, 0, 1'b1);

    // Reset after the second transfer aborts the stream without o_done.
    bcd = 16'h0123; comma_pos = 3'd1; sign = 1'b0; ready = 1'b1; print_start = 1'b1;
    @(negedge clk);
    print_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_valid", valid, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", valid, 0);
    check("abort_idle", idle, 1);
    check("abort_symbol", symbol, SYM_INVALID);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_stays_idle", idle, 1);
    end
    build_model(16'h0123, 1, 1'b0);
    run_print(16'h0123, 3'd1, 1'b0, 0, 1'b0);

    // Randomized values, comma positions and backpressure.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] rp;
      logic       rs;
      for (int j = 0; j < ND; j++)
        rb[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rp = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      build_model(rb, int'(rp), rs);
      run_print(rb, rp, rs, 2, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dau_output_encoder.md
# dau_output_encoder

Print-path counterpart of the DAU input decoder. On a print request it captures one BCD stack value (digits, comma position, sign) and serialises it as a stream of DAU symbols (optional minus, integer digits, comma, fractional digits, new line) over a valid/ready interface toward the symbol transmitter. Its completion pulse drives the decoder's `i_operation_done`, re-arming symbol input.

## Interface
- `NUM_DIGITS`, default 4: BCD digits per stack value.
- `POS_WIDTH`, default `$clog2(NUM_DIGITS+1)`: width of the comma-position field.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_print_start`  in  1  one-cycle request; sampled only when `o_idle`=1.
- `i_bcd`  in  `4*NUM_DIGITS`  value digits; `[3:0]` least significant.
- `i_comma_pos`  in  `POS_WIDTH`  number of fractional digits.
- `i_sign`  in  1  1 = negative.
- `o_valid`  out  1  `o_symbol` holds a symbol.
- `o_symbol`  out  `` `DAU_SYM_WIDTH ``  symbol code.
- `i_ready`  in  1  downstream accepts; a transfer occurs when `o_valid` && `i_ready`.
- `o_done`  out  1  one-cycle pulse after `DAU_SYM_NEW_LINE` transfers.
- `o_idle`  out  1  high in IDLE.

## Operation
- Capture on start in IDLE: `i_bcd`, `i_sign`, and `i_comma_pos` clamped to `NUM_DIGITS-1`, so there is always at least one integer digit.
- Zero value: all captured digits are 0.
- Digit index runs from `NUM_DIGITS-1` down to 0. Integer digits are indices ≥ clamped comma position.
- Digit symbol = `` `DAU_SYM_0 `` + digit value. Digit values above 9 are emitted as `` `DAU_SYM_9 ``.
- FSM states:
  - IDLE → SIGN if `i_sign` && nonzero; otherwise IDLE → INT. A negative zero never emits a minus.
  - SIGN emits `` `DAU_SYM_MINUS `` → INT.
  - INT emits integer digits, most significant first.
  - INT → COMMA after index = comma position if comma position > 0; otherwise INT → NL.
  - COMMA emits `` `DAU_SYM_COMMA `` → FRAC.
  - FRAC emits the remaining digits down to index 0 → NL.
  - NL emits `` `DAU_SYM_NEW_LINE `` → DONE.
  - DONE pulses `o_done` → IDLE.
- Leading-zero suppression (see Configuration): on INT entry, the index jumps to the highest nonzero integer digit, floored at the comma position. The least significant integer digit is therefore always emitted.
- `i_print_start` outside IDLE is ignored; there is no queueing.
- Input buses matter only in the capture cycle.

## Timing
- Reset values: `o_valid`=0, `o_symbol`=`` `DAU_SYM_INVALID ``, `o_done`=0, `o_idle`=1, state IDLE, capture registers 0.
- Outputs are registered. Start sampled at edge N → first symbol valid after edge N+1.
- On a transfer at an edge, the next symbol is loaded at that same edge. With `i_ready` held at 1, one symbol is transferred per cycle, with no bubbles.
- While `o_valid`=1 and `i_ready`=0, `o_symbol` and the state hold stable. `o_valid` never drops without a transfer, except on reset.
- `o_done` rises the cycle after the NL transfer and lasts exactly one cycle. `o_idle` rises together with it, so a new start is accepted from that cycle on.
- Reset mid-stream aborts immediately and asynchronously to the reset values. No `o_done` is produced.

## Configuration
- `DAU_ENC_LZ_SUPPRESS_EN` defined: leading integer zeros are suppressed as described in Operation.
- Not defined: all `NUM_DIGITS-comma_pos` integer digits are emitted, including leading zeros. The `dau_lz_scan` instance is not compiled in.

## Structure
- Symbol codes and `DAU_SYM_WIDTH` come from the shared `dau_symbols.vh`. `DAU_SYM_0..DAU_SYM_9` are contiguous and ascending there.
- FSM state encodings are localparams, private to the module.
- One sub-module, `dau_lz_scan`: combinational priority encoder returning the index of the highest nonzero digit plus an all-zero flag. It is also used for zero detection; when the macro is off, zero detection uses a plain OR-reduction instead.

## Test plan
- `NUM_DIGITS`=4, `i_bcd`=0x0123, comma 1, sign 0, `i_ready`=1 → 1, 2, COMMA, 3, NEW_LINE on 5 consecutive cycles; `o_done` on the 6th.
- `i_bcd`=0x0005, comma 2, sign 1 → MINUS, 0, COMMA, 0, 5, NEW_LINE.
- `i_bcd`=0x0000, comma 0, sign 1 → 0, NEW_LINE; no MINUS.
- 0x0123 with `i_ready` toggling 1,0,1,0… → same 5 symbols, each held stable while not ready; no drops or duplicates.
- Second `i_print_start` mid-stream → ignored. Asserting `i_rst` after the 2nd symbol → `o_valid`=0 and `o_idle`=1 immediately, no `o_done`; a fresh start afterwards produces the full stream.
- Macro undefined, 0x0123 comma 1 → 0, 1, 2, COMMA, 3, NEW_LINE. Comma 7 is clamped to 3 → 0, COMMA, 1, 2, 3, NEW_LINE.
